see_cone_campaign: RTL

- Parametrised successor to the single extracted NAND/NOR logic-cone netlists used in SEE error analysis.
- Holds a generic alternating NAND/NOR chain cone of configurable depth and input width, plus an on-chip fault-injection campaign engine.
- For every fault site and every input pattern, evaluates the golden cone against a faulted copy and counts observable (unmasked) errors per node.
- Produces per-node logical-masking statistics in hardware, with no external stimulus.

---
 rtl/see_cone_pkg.sv | 31 +++
 rtl/see_cone_eval.sv | 52 +++++
 rtl/see_cone_campaign.sv | 133 +++++++++++++
 3 files changed

// File: rtl/see_cone_pkg.sv
// Shared types and helpers for the SEE logic-cone fault-injection campaign.
// Fault modes, campaign FSM states and the cone input-index mapping.
package see_cone_pkg;

    typedef enum logic [1:0] {
        SET_INV = 2'd0,
        SA0     = 2'd1,
        SA1     = 2'd2
    } fault_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Secondary input of node k is in[(k+1) mod N_IN].
    function automatic int in_idx(input int k, input int n_in);
        return (k + 1) % n_in;
    endfunction

    // Encoding 3 has no dedicated fault type and behaves as an inversion.
    function automatic fault_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return SA0;
            2'd2:    return SA1;
            default: return SET_INV;
        endcase
    endfunction

endpackage

// File: rtl/see_cone_eval.sv
// Purely combinational alternating NAND/NOR chain cone with an optional
// fault applied to one node before it feeds the rest of the chain.
module see_cone_eval
    import see_cone_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int DEPTH = 6,
    parameter int IDX_W = 3
) (
    input  logic [N_IN-1:0]  pattern,
    input  logic             fault_en,
    input  logic [IDX_W-1:0] fault_site,
    input  fault_mode_e      fault_mode,
    output logic             cone_out
);

    logic            acc;
    logic            raw;
    logic            side_bit;
    logic [N_IN-1:0] shifted;

    // NOTE: blocking assignments are correct here; acc carries the node value
    // down the chain within one evaluation and must never become state.
    always_comb begin
        acc      = 1'b0;
        raw      = 1'b0;
        side_bit = 1'b0;
        shifted  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            shifted  = pattern >> in_idx(k, N_IN);
            side_bit = shifted[0];
            if (k == 0)
                raw = ~(pattern[0] & pattern[1]);
            else if (k % 2 == 1)
                raw = ~(acc | side_bit);
            else
                raw = ~(acc & side_bit);

            if (fault_en && int'(fault_site) == k) begin
                case (fault_mode)
                    SA0:     acc = 1'b0;
                    SA1:     acc = 1'b1;
                    default: acc = ~raw;
                endcase
            end else begin
                acc = raw;
            end
        end
        cone_out = acc;
    end

endmodule

// File: rtl/see_cone_campaign.sv
// On-chip fault-injection campaign: sweeps every (site, pattern) pair, compares a
// golden cone with a faulted copy and accumulates per-node unmasked error counts.
module see_cone_campaign
    import see_cone_pkg::*;
#(
    parameter  int N_IN  = 8,
    parameter  int DEPTH = 6,
    parameter  int CNT_W = 9,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode,
    output logic                   busy,
    output logic                   done,
    input  logic [IDX_W-1:0]       rd_node,
    output logic [CNT_W-1:0]       rd_count,
    output logic [CNT_W+IDX_W-1:0] total_err
);

    state_e           state, next_state;
    fault_mode_e      mode_q;
    logic [N_IN-1:0]  pattern;
    logic [IDX_W-1:0] site;
    logic [IDX_W-1:0] err_site;
    logic             err_valid;
    logic             err_bit;
    logic             flush;
    logic             clear;
    logic             issue;
    logic             last;
    logic             golden;
    logic             faulted;
    logic [CNT_W-1:0] cnt [DEPTH];

    see_cone_eval #(.N_IN(N_IN), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_golden (
        .pattern    (pattern),
        .fault_en   (1'b0),
        .fault_site (site),
        .fault_mode (mode_q),
        .cone_out   (golden)
    );

    see_cone_eval #(.N_IN(N_IN), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_faulted (
        .pattern    (pattern),
        .fault_en   (1'b1),
        .fault_site (site),
        .fault_mode (mode_q),
        .cone_out   (faulted)
    );

    assign last     = (pattern == '1) && (site == IDX_W'(DEPTH - 1));
    assign busy     = (state == RUN);
    assign rd_count = (int'(rd_node) < DEPTH) ? cnt[rd_node] : '0;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        next_state = state;
        clear      = 1'b0;
        issue      = 1'b0;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    next_state = RUN;
                    clear      = 1'b1;
                end
                RUN: if (flush) next_state = DONE;
                     else       issue      = 1'b1;
                default: next_state = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: the counter array is small and is cleared at reset and per campaign,
    // so it is built from flops rather than a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            pattern   <= '0;
            site      <= '0;
            flush     <= 1'b0;
            err_valid <= 1'b0;
            err_bit   <= 1'b0;
            err_site  <= '0;
            mode_q    <= SET_INV;
            total_err <= '0;
            for (int i = 0; i < DEPTH; i++) cnt[i] <= '0;
        end else begin
            done <= (state == RUN) && (next_state == DONE);
            if (clear) begin
                pattern   <= '0;
                site      <= '0;
                flush     <= 1'b0;
                err_valid <= 1'b0;
                err_bit   <= 1'b0;
                err_site  <= '0;
                mode_q    <= decode_mode(mode);
                total_err <= '0;
                for (int i = 0; i < DEPTH; i++) cnt[i] <= '0;
            end else begin
                err_valid <= issue;
                err_bit   <= golden ^ faulted;
                err_site  <= site;
                if (issue) begin
                    if (last) begin
                        flush <= 1'b1;
                    end else if (pattern == '1) begin
                        pattern <= '0;
                        site    <= site + 1'b1;
                    end else begin
                        pattern <= pattern + 1'b1;
                    end
                end
                // Mismatch registered last cycle lands in its site counter now.
                if (err_valid && err_bit) begin
                    if (cnt[err_site] != '1) cnt[err_site] <= cnt[err_site] + 1'b1;
                    if (total_err != '1)     total_err     <= total_err + 1'b1;
                end
            end
        end
    end

endmodule
